// File: rtl/dog_pkg.sv
// Shared widths, index types and period arithmetic for the dog motion sequencer.
package dog_pkg;

    localparam int DEF_NUM_SPEEDS  = 4;
    localparam int DEF_NUM_ACTIONS = 8;

    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    localparam int SPD_W = idx_w(DEF_NUM_SPEEDS);
    localparam int ACT_W = idx_w(DEF_NUM_ACTIONS);

    typedef logic [SPD_W-1:0] speed_t;
    typedef logic [ACT_W-1:0] action_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Step period in clk cycles for speed s; the slowest non-zero speed doubles most.
    function automatic longint unsigned period(input int s, input int base_ticks,
                                               input int num_speeds);
        return 64'(base_ticks) << (num_speeds - 1 - s);
    endfunction

endpackage

// File: rtl/dog_motion_sequencer_step_timer.sv
// Loadable tick counter producing a terminal-count pulse every term+1 enabled cycles.
module step_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    assign tc = enable && (count_r == term);

    // Tick counter: clear has priority, wraps to zero on terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear || tc) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/dog_motion_sequencer.sv
// Toy-dog speed/action sequencer on a single clock with tick-timer stepping.
// Optional DOG_PINGPONG_EN: action index bounces between the ends instead of wrapping.
module dog_motion_sequencer
    import dog_pkg::*;
#(
    parameter int  NUM_SPEEDS  = 4,
    parameter int  NUM_ACTIONS = 8,
    parameter int  BASE_TICKS  = 50000000,
    localparam int SPEED_W     = idx_w(NUM_SPEEDS),
    localparam int ACTION_W    = idx_w(NUM_ACTIONS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                btn,
    input  logic                act_rst,
    output logic [SPEED_W-1:0]  speed_o,
    output logic [ACTION_W-1:0] action_o,
    output logic                step_o,
    output logic                running_o
);

    localparam int CNT_W = $clog2(period(1, BASE_TICKS, NUM_SPEEDS));

    logic                btn_q_r;
    logic [SPEED_W-1:0]  speed_r;
    logic [ACTION_W-1:0] action_r;
    logic                step_r;

    logic                press_s;
    logic                speed_up_s;
    logic                run_s;
    logic                tc_s;
    logic [CNT_W-1:0]    term_s;
    logic [SPEED_W-1:0]  speed_next_s;
    logic [ACTION_W-1:0] action_next_s;

    assign press_s    = btn & ~btn_q_r;
    assign speed_up_s = en & press_s;
    assign run_s      = en && (speed_r != {SPEED_W{1'b0}});
    // Terminal value for speed 0 is meaningless; the timer is disabled there.
    assign term_s     = CNT_W'(period(int'(speed_r), BASE_TICKS, NUM_SPEEDS) - 64'd1);

    step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (act_rst | speed_up_s),
        .enable (run_s),
        .term   (term_s),
        .tc     (tc_s)
    );

    // Next speed level, wrapping from the fastest back to stopped.
    always_comb begin
        speed_next_s = speed_r;
        if (speed_r == SPEED_W'(NUM_SPEEDS - 1)) begin
            speed_next_s = {SPEED_W{1'b0}};
        end else begin
            speed_next_s = speed_r + SPEED_W'(1);
        end
    end

`ifdef DOG_PINGPONG_EN
    dir_e dir_r;
    dir_e dir_next_s;

    // Bounce: the direction flips as soon as an end value is reached.
    always_comb begin
        action_next_s = action_r;
        dir_next_s    = dir_r;
        case (dir_r)
            DIR_UP: begin
                action_next_s = action_r + ACTION_W'(1);
                if (action_next_s == ACTION_W'(NUM_ACTIONS - 1)) begin
                    dir_next_s = DIR_DOWN;
                end else begin
                    dir_next_s = DIR_UP;
                end
            end
            DIR_DOWN: begin
                action_next_s = action_r - ACTION_W'(1);
                if (action_next_s == {ACTION_W{1'b0}}) begin
                    dir_next_s = DIR_UP;
                end else begin
                    dir_next_s = DIR_DOWN;
                end
            end
            default: begin
                action_next_s = {ACTION_W{1'b0}};
                dir_next_s    = DIR_UP;
            end
        endcase
    end

    // Direction register follows the action register's priority order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_r <= DIR_UP;
        end else if (act_rst) begin
            dir_r <= DIR_UP;
        end else if (tc_s) begin
            dir_r <= dir_next_s;
        end else begin
            dir_r <= dir_r;
        end
    end
`else
    // Wrap from the last action back to the first.
    always_comb begin
        action_next_s = action_r;
        if (action_r == ACTION_W'(NUM_ACTIONS - 1)) begin
            action_next_s = {ACTION_W{1'b0}};
        end else begin
            action_next_s = action_r + ACTION_W'(1);
        end
    end
`endif

    // Button history and speed level; a press only counts while enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q_r <= 1'b0;
            speed_r <= {SPEED_W{1'b0}};
        end else begin
            btn_q_r <= btn;
            if (speed_up_s) begin
                speed_r <= speed_next_s;
            end else begin
                speed_r <= speed_r;
            end
        end
    end

    // Action index and step pulse; act_rst beats a coincident terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            action_r <= {ACTION_W{1'b0}};
            step_r   <= 1'b0;
        end else if (act_rst) begin
            action_r <= {ACTION_W{1'b0}};
            step_r   <= 1'b0;
        end else if (tc_s) begin
            action_r <= action_next_s;
            step_r   <= 1'b1;
        end else begin
            action_r <= action_r;
            step_r   <= 1'b0;
        end
    end

    assign speed_o   = speed_r;
    assign action_o  = action_r;
    assign step_o    = step_r;
    assign running_o = run_s;

endmodule

// File: tb/tb_dog_motion_sequencer.sv
// Directed bench for dog_motion_sequencer with a step-count reference model.
module tb_dog_motion_sequencer;

    localparam int NS = 4;
    localparam int NA = 8;
    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       btn = 1'b0;
    logic       act_rst = 1'b0;
    logic [1:0] speed_o;
    logic [2:0] action_o;
    logic       step_o;
    logic       running_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference: speed level, number of steps since last action clear, cycles since timer clear.
    int m_speed = 0;
    int m_k = 0;
    int m_el = 0;
    bit m_btnq = 1'b0;
    bit m_step = 1'b0;
    bit m_valid = 1'b0;

    dog_motion_sequencer #(
        .NUM_SPEEDS  (NS),
        .NUM_ACTIONS (NA),
        .BASE_TICKS  (BT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .btn       (btn),
        .act_rst   (act_rst),
        .speed_o   (speed_o),
        .action_o  (action_o),
        .step_o    (step_o),
        .running_o (running_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int per(input int s);
        return BT << (NS - 1 - s);
    endfunction

    // The k-th position of the action walk.
    function automatic int exp_action(input int k);
`ifdef DOG_PINGPONG_EN
        int m;
        m = k % (2 * NA - 2);
        return (m < NA) ? m : (2 * NA - 2 - m);
`else
        return k % NA;
`endif
    endfunction

    // Model update on each edge, then compare shortly after.
    always @(posedge clk) begin
        bit press;
        bit tc;
        if (!rst_n) begin
            m_speed = 0; m_k = 0; m_el = 0; m_btnq = 1'b0; m_step = 1'b0;
            m_valid = 1'b1;
        end else begin
            press  = btn && !m_btnq;
            m_btnq = btn;
            tc     = en && (m_speed != 0) && (m_el == per(m_speed) - 1);
            m_step = !act_rst && tc;
            if (act_rst) m_k = 0;
            else if (tc) m_k++;
            if (act_rst || (en && press) || tc) m_el = 0;
            else if (en && m_speed != 0) m_el++;
            if (en && press) m_speed = (m_speed + 1) % NS;
        end
        #1;
        if (m_valid) begin
            check("model_speed", 32'(speed_o), 32'(m_speed));
            check("model_action", 32'(action_o), 32'(exp_action(m_k)));
            check("model_step", 32'(step_o), 32'(m_step));
            check("model_running", 32'(running_o), 32'(en && m_speed != 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_once;
        btn = 1'b1; cyc(1);
        btn = 1'b0; cyc(1);
    endtask

    initial begin
        // 1: reset then idle
        rst_n = 1'b0; cyc(3);
        rst_n = 1'b1; cyc(100);
        check("idle_speed", 32'(speed_o), 32'd0);
        check("idle_action", 32'(action_o), 32'd0);
        check("idle_step", 32'(step_o), 32'd0);

        // 2: held button gives a single increment, period 16
        en = 1'b1; btn = 1'b1; cyc(1);
        check("hold_speed1", 32'(speed_o), 32'd1);
        cyc(16);
        check("first_step_action", 32'(action_o), 32'd1);
        check("first_step_pulse", 32'(step_o), 32'd1);
        cyc(4);
        btn = 1'b0;
        cyc(108);
`ifdef DOG_PINGPONG_EN
        check("eighth_step_action", 32'(action_o), 32'd6);
`else
        check("eighth_step_action", 32'(action_o), 32'd0);
`endif
        check("eighth_step_pulse", 32'(step_o), 32'd1);
        check("hold_speed_still1", 32'(speed_o), 32'd1);

        // 3: presses up to speed 3, period 4, then wrap to 0 and disabled presses
        press_once;
        btn = 1'b1; cyc(1);
        check("speed3", 32'(speed_o), 32'd3);
        btn = 1'b0; cyc(4);
        check("p4_step", 32'(step_o), 32'd1);
`ifdef DOG_PINGPONG_EN
        check("p4_action", 32'(action_o), 32'd5);
`else
        check("p4_action", 32'(action_o), 32'd1);
`endif
        cyc(20);
        btn = 1'b1; cyc(1);
        check("wrap_speed0", 32'(speed_o), 32'd0);
        btn = 1'b0; cyc(20);
        en = 1'b0;
        press_once;
        check("en0_press_speed", 32'(speed_o), 32'd0);
        check("en0_running", 32'(running_o), 32'd0);
        btn = 1'b1; cyc(1);
        en = 1'b1; cyc(2);
        check("en_rise_held_btn", 32'(speed_o), 32'd0);
        btn = 1'b0; cyc(1);

        // 4: freeze mid-count at counter=2
        press_once;
        press_once;
        btn = 1'b1; cyc(1);
        btn = 1'b0; cyc(2);
        check("freeze_speed3", 32'(speed_o), 32'd3);
        en = 1'b0; cyc(10);
        check("freeze_step", 32'(step_o), 32'd0);
        check("freeze_running", 32'(running_o), 32'd0);
        en = 1'b1; cyc(1);
        check("resume_no_step", 32'(step_o), 32'd0);
        cyc(1);
        check("resume_step", 32'(step_o), 32'd1);

        // 5: act_rst on terminal count with action 5
        act_rst = 1'b1; cyc(1);
        act_rst = 1'b0;
        check("act_rst_clear", 32'(action_o), 32'd0);
        cyc(20);
        check("five_steps", 32'(action_o), 32'd5);
        cyc(3);
        act_rst = 1'b1; cyc(1);
        check("act_rst_tc_action", 32'(action_o), 32'd0);
        check("act_rst_tc_step", 32'(step_o), 32'd0);
        act_rst = 1'b0; cyc(4);
        check("after_act_rst_action", 32'(action_o), 32'd1);
        check("after_act_rst_step", 32'(step_o), 32'd1);

        // press coincident with terminal count: step at old speed, speed wraps
        cyc(3);
        btn = 1'b1; cyc(1);
        check("press_tc_step", 32'(step_o), 32'd1);
        check("press_tc_action", 32'(action_o), 32'd2);
        check("press_tc_speed", 32'(speed_o), 32'd0);
        btn = 1'b0; cyc(1);

        // 6: long run at speed 3 to expose wrap vs bounce
        press_once;
        press_once;
        press_once;
        act_rst = 1'b1; cyc(1);
        act_rst = 1'b0;
        cyc(32);
`ifdef DOG_PINGPONG_EN
        check("run8_action", 32'(action_o), 32'd6);
`else
        check("run8_action", 32'(action_o), 32'd0);
`endif
        cyc(32);
`ifdef DOG_PINGPONG_EN
        check("run16_action", 32'(action_o), 32'd2);
`else
        check("run16_action", 32'(action_o), 32'd0);
`endif

        // press and act_rst together both apply
        cyc(2);
        btn = 1'b1; act_rst = 1'b1; cyc(1);
        check("both_speed", 32'(speed_o), 32'd0);
        check("both_action", 32'(action_o), 32'd0);
        check("both_step", 32'(step_o), 32'd0);
        btn = 1'b0; act_rst = 1'b0; cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
